// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, branch resolve, dmem handshake, MEM/WB register.
// Stalls upstream while a data access is outstanding; sticky error on misalign/timeout.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        flush_in,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_branch_target,
    input  logic        ex_zero,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_branch,
    output logic        stall_out,
    output logic        pc_src_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] ex_mem_result,
    output logic [4:0]  ex_mem_rd_addr,
    output logic        ex_mem_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_read_data,
    output logic        err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] count;

    logic        exm_valid;
    logic [31:0] exm_alu_result;
    logic [31:0] exm_branch_target;
    logic        exm_zero;
    logic [31:0] exm_store_data;
    logic [4:0]  exm_rd_addr;
    logic        exm_mem_to_reg;
    logic        exm_reg_write;
    logic        exm_mem_read;
    logic        exm_mem_write;
    logic        exm_branch;

    logic mem_access;
    logic aligned;
    logic misaligned;
    logic mem_op;
    logic in_err;

    assign mem_access = exm_valid & (exm_mem_read | exm_mem_write);
    assign aligned    = (exm_alu_result[1:0] == 2'b00);
    assign misaligned = mem_access & ~aligned;
    assign mem_op     = mem_access & aligned & ~err_out;
    assign in_err     = (state == S_ERR);

    assign dmem_req   = mem_op & ~in_err;
    assign stall_out  = mem_op & ~dmem_ack & ~in_err;
    assign dmem_we    = exm_mem_write;
    assign dmem_addr  = exm_alu_result;
    assign dmem_wdata = exm_store_data;

    assign pc_src_out        = exm_valid & exm_branch & exm_zero;
    assign branch_target_out = exm_branch_target;
    assign ex_mem_result     = exm_alu_result;
    assign ex_mem_rd_addr    = exm_rd_addr;
    assign ex_mem_reg_write  = exm_valid & exm_reg_write;

    // EX/MEM register: capture when not stalled, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_valid         <= 1'b0;
            exm_alu_result    <= '0;
            exm_branch_target <= '0;
            exm_zero          <= 1'b0;
            exm_store_data    <= '0;
            exm_rd_addr       <= '0;
            exm_mem_to_reg    <= 1'b0;
            exm_reg_write     <= 1'b0;
            exm_mem_read      <= 1'b0;
            exm_mem_write     <= 1'b0;
            exm_branch        <= 1'b0;
        end else if (!stall_out) begin
            exm_valid         <= ex_valid & ~flush_in;
            exm_alu_result    <= ex_alu_result;
            exm_branch_target <= ex_branch_target;
            exm_zero          <= ex_zero;
            exm_store_data    <= ex_store_data;
            exm_rd_addr       <= ex_rd_addr;
            exm_mem_to_reg    <= ex_mem_to_reg;
            exm_reg_write     <= ex_reg_write;
            exm_mem_read      <= ex_mem_read;
            exm_mem_write     <= ex_mem_write;
            exm_branch        <= ex_branch;
        end
    end

    // Access FSM: count request cycles, give up after TIMEOUT, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= '0;
            err_out <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mem_op && !dmem_ack) begin
                        state <= S_WAIT;
                        count <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        state   <= S_ERR;
                        count   <= '0;
                        err_out <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                end
            endcase
            if (misaligned) begin
                err_out <= 1'b1;
            end
        end
    end

    // MEM/WB register: bubbles on stall, misalign or abandoned access
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd_addr    <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
        end else begin
            wb_valid      <= exm_valid & ~stall_out & ~misaligned & ~in_err;
            wb_reg_write  <= exm_reg_write;
            wb_mem_to_reg <= exm_mem_to_reg;
            wb_rd_addr    <= exm_rd_addr;
            wb_alu_result <= exm_alu_result;
            if (exm_mem_read && dmem_req && dmem_ack) begin
                wb_read_data <= dmem_rdata;
            end else begin
                wb_read_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model.
// Inputs driven on the falling edge, outputs compared 1 ns later.
module tb_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, flush_in, ex_zero;
    logic [31:0] ex_alu_result, ex_branch_target, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic        stall_out, pc_src_out;
    logic [31:0] branch_target_out, ex_mem_result;
    logic [4:0]  ex_mem_rd_addr;
    logic        ex_mem_reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_alu_result, wb_read_data;
    logic        err_out;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .flush_in(flush_in),
        .ex_alu_result(ex_alu_result), .ex_branch_target(ex_branch_target),
        .ex_zero(ex_zero), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .stall_out(stall_out), .pc_src_out(pc_src_out),
        .branch_target_out(branch_target_out), .ex_mem_result(ex_mem_result),
        .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_reg_write(ex_mem_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd_addr(wb_rd_addr), .wb_alu_result(wb_alu_result),
        .wb_read_data(wb_read_data), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] alu, tgt, sd;
        logic [4:0]  rd;
        bit          m2r, rw, mr, mw, br, z;
    } ins_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference state: the instruction sitting in MEM, how long its access has
    // been waiting, whether the error flag is raised, and the last retired slot
    ins_t        m;
    int          waited;
    bit          err, abandon;
    bit          wv, wrw, wm2r;
    logic [4:0]  wrd;
    logic [31:0] walu, wrdata;

    task automatic model_reset();
        m = '{v: 0, alu: 0, tgt: 0, sd: 0, rd: 0, m2r: 0, rw: 0, mr: 0, mw: 0, br: 0, z: 0};
        waited = 0; err = 0; abandon = 0;
        wv = 0; wrw = 0; wm2r = 0; wrd = 0; walu = 0; wrdata = 0;
    endtask

    // drive one random EX instruction; kind<0 picks randomly
    task automatic drive(input int kind, input int ack_pct, input bit allow_mis);
        int k;
        k = (kind < 0) ? int'($urandom_range(0, 5)) : kind;
        ex_valid = (k != 0);
        flush_in = ($urandom_range(0, 7) == 0);
        ex_alu_result = {$urandom_range(0, 255), 2'b00};
        if (allow_mis && $urandom_range(0, 19) == 0)
            ex_alu_result[1:0] = 2'($urandom_range(1, 3));
        ex_branch_target = $urandom;
        ex_zero = $urandom_range(0, 1) == 1;
        ex_store_data = $urandom;
        ex_rd_addr = 5'($urandom);
        ex_reg_write = (k == 1 || k == 2 || k == 5);
        ex_mem_to_reg = (k == 2);
        ex_mem_read = (k == 2);
        ex_mem_write = (k == 3);
        ex_branch = (k == 4);
        dmem_ack = ($urandom_range(0, 99) < ack_pct);
        dmem_rdata = $urandom;
    endtask

    // compare current outputs against the model, then advance model one edge
    task automatic step();
        bit is_mem, mis, op, req, stall, ack_done, timed_out;
        #1;
        is_mem = m.v && (m.mr || m.mw);
        mis = is_mem && (m.alu[1:0] != 2'b00);
        op = is_mem && !mis && !err;
        req = op && !abandon;
        stall = req && !dmem_ack;
        check("stall", 32'(stall_out), 32'(stall));
        check("req", 32'(dmem_req), 32'(req));
        if (req) begin
            check("we", 32'(dmem_we), 32'(m.mw));
            check("addr", dmem_addr, m.alu);
            if (m.mw) check("wdata", dmem_wdata, m.sd);
        end
        check("pc_src", 32'(pc_src_out), 32'(m.v && m.br && m.z));
        check("br_tgt", branch_target_out, m.tgt);
        check("fwd_res", ex_mem_result, m.alu);
        check("fwd_rd", 32'(ex_mem_rd_addr), 32'(m.rd));
        check("fwd_rw", 32'(ex_mem_reg_write), 32'(m.v && m.rw));
        check("wb_valid", 32'(wb_valid), 32'(wv));
        if (wv) begin
            check("wb_rw", 32'(wb_reg_write), 32'(wrw));
            check("wb_m2r", 32'(wb_mem_to_reg), 32'(wm2r));
            check("wb_rd", 32'(wb_rd_addr), 32'(wrd));
            check("wb_alu", wb_alu_result, walu);
        end
        check("wb_rdata", wb_read_data, wrdata);
        check("err", 32'(err_out), 32'(err));

        ack_done = req && dmem_ack;
        timed_out = req && !dmem_ack && (waited + 1 >= TIMEOUT);
        @(posedge clk);
        if (rst) begin
            model_reset();
            return;
        end
        wv = m.v && !stall && !mis && !abandon;
        wrw = m.rw; wm2r = m.m2r; wrd = m.rd; walu = m.alu;
        wrdata = (m.mr && ack_done) ? dmem_rdata : 32'h0;
        if (stall && !timed_out) waited = waited + 1;
        else waited = 0;
        abandon = timed_out;
        if (mis || timed_out) err = 1;
        if (!stall) begin
            m.v = ex_valid && !flush_in;
            m.alu = ex_alu_result; m.tgt = ex_branch_target; m.sd = ex_store_data;
            m.rd = ex_rd_addr; m.m2r = ex_mem_to_reg; m.rw = ex_reg_write;
            m.mr = ex_mem_read; m.mw = ex_mem_write; m.br = ex_branch; m.z = ex_zero;
        end
    endtask

    task automatic cyc(input bit r, input int kind, input int ack_pct, input bit mis);
        @(negedge clk);
        rst = r;
        drive(kind, ack_pct, mis);
        step();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        m.v = 1; // first edge is a reset; model must match reset, not this garbage
        @(posedge clk);
        model_reset();
        cyc(1, 0, 0, 0);
        // reset state must be all zero
        for (int i = 0; i < 300; i++) cyc(0, -1, 60, 0);
        // long unacked loads: timeout, sticky error, then ignored accesses
        for (int i = 0; i < 40; i++) cyc(0, 2, 0, 0);
        cyc(1, 0, 0, 0);
        // reset mid-wait
        for (int i = 0; i < 5; i++) cyc(0, 3, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        // mixed traffic with misaligned accesses and occasional resets
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 49) == 0), -1, $urandom_range(20, 90), 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
